// File: rtl/esh_pkg.sv
// esh_pkg: shared FSM state type, slave-select decode and default widths for apb_sum_bridge
package esh_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_SLAVES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
  function automatic logic [15:0] sel_onehot(input logic [3:0] s);
    return 16'(1) << s;
  endfunction
endpackage

// File: rtl/apb_join_stage.sv
// apb_join_stage: joins command and operand streams and captures the command with its widened sum
// Ports: clk/rst (sync, active-low); idle_i enables the join; a_*_i/b_*_i are the two input streams;
// a_ready_o/b_ready_o/accept_o are the handshake; addr_o/sel_o/write_o/wdata_o are the captured command.
module apb_join_stage import esh_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle_i,
  input  logic                  a_valid_i,
  input  logic                  a_write_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic [SW-1:0]         a_sel_i,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  a_ready_o,
  output logic                  b_ready_o,
  output logic                  accept_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [SW-1:0]         sel_o,
  output logic                  write_o,
  output logic [DATA_WIDTH:0]   wdata_o
);
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SW-1:0]         sel_q;
  logic                  write_q;
  logic [DATA_WIDTH:0]   wdata_q, wdata_d;
  // reads never wait for or consume operand B
  assign accept_o  = idle_i && rst && a_valid_i && (!a_write_i || b_valid_i);
  assign a_ready_o = accept_o;
  assign b_ready_o = accept_o && a_write_i;
  assign wdata_d   = a_write_i ? {1'b0, a_wdata_i} + {1'b0, b_data_i} : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept_o) begin
      addr_q  <= a_addr_i;
      sel_q   <= a_sel_i;
      write_q <= a_write_i;
      wdata_q <= wdata_d;
    end
  end
  assign addr_o  = addr_q;
  assign sel_o   = sel_q;
  assign write_o = write_q;
  assign wdata_o = wdata_q;
endmodule

// File: rtl/apb_sum_bridge.sv
// apb_sum_bridge: joins command/operand streams, sums operands for writes and runs one APB transfer per command
// Ports: clk/rst (sync, active-low); a_* command stream; b_* operand stream; p* APB master to NUM_SLAVES
// slaves (prdata/pready/pslverr muxed externally); rsp_* response stream with read data and error.
// Optional APB_SUM_BRIDGE_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without pready.
module apb_sum_bridge import esh_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [SW-1:0]         a_sel,
  input  logic                  a_write,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH:0]   pwdata,
  output logic                  pwrite,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  input  logic [DATA_WIDTH:0]   prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH:0]   rsp_data,
  output logic                  rsp_err
);
  apb_state_t          state_q, state_d;
  logic [SW-1:0]       sel_q;
  logic [DATA_WIDTH:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                accept, legal, expire;
  apb_join_stage #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .SW(SW)) u_join (
    .clk(clk), .rst(rst), .idle_i(state_q == IDLE),
    .a_valid_i(a_valid), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_sel_i(a_sel),
    .b_valid_i(b_valid), .b_data_i(b_data),
    .a_ready_o(a_ready), .b_ready_o(b_ready), .accept_o(accept),
    .addr_o(paddr), .sel_o(sel_q), .write_o(pwrite), .wdata_o(pwdata)
  );
  // only reachable when NUM_SLAVES is not a power of two
  assign legal = 32'(a_sel) < NUM_SLAVES;
`ifdef APB_SUM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst || state_q == SETUP) cnt_q <= '0;
    else if (state_q == ACCESS && !pready) cnt_q <= cnt_q + CW'(1);
  end
  // cnt_q counts completed ACCESS cycles, so the last allowed one sees TIMEOUT_CYCLES-1
  assign expire = state_q == ACCESS && !pready && 32'(cnt_q) == TIMEOUT_CYCLES - 1;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d    = legal ? SETUP : RESP;
        rsp_data_d = '0;
        rsp_err_d  = !legal;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready || expire) begin
        state_d    = RESP;
        rsp_data_d = (!pready || pwrite || pslverr) ? '0 : prdata;
        rsp_err_d  = !pready || pslverr;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  assign psel      = (state_q == SETUP || state_q == ACCESS) ? NUM_SLAVES'(sel_onehot(4'(sel_q))) : '0;
  assign penable   = state_q == ACCESS;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_sum_bridge.sv
// tb_apb_sum_bridge: directed and randomized checks of apb_sum_bridge against a transaction-level model
// Three slaves are used so that a 2-bit select can name an illegal slave (index 3).
module tb_apb_sum_bridge;
  logic clk = 0, rst = 0;
  logic a_valid = 0, a_write = 0, b_valid = 0, pready = 0, pslverr = 0, rsp_ready = 1;
  logic [3:0] a_addr = 0;
  logic [15:0] a_wdata = 0, b_data = 0;
  logic [1:0] a_sel = 0;
  logic [16:0] prdata = 0;
  logic a_ready, b_ready, pwrite, penable, rsp_valid, rsp_err;
  logic [3:0] paddr;
  logic [16:0] pwdata, rsp_data;
  logic [2:0] psel;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  apb_sum_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_SLAVES(3), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_sel(a_sel), .a_write(a_write), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One command from offer to response; expectations come from the transfer rules, not the FSM.
  task automatic txn(input bit wr, input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] a,
                     input logic [15:0] b, input int waits, input bit err, input logic [16:0] rd, input int rdly);
    int exp_wd, exp_rd;
    bit legal, exp_err;
    legal   = sel < 3;
    exp_wd  = wr ? int'(a) + int'(b) : 0;
    exp_err = !legal || err;
    exp_rd  = (!legal || wr || err) ? 0 : int'(rd);
    a_valid = 1; a_write = wr; a_addr = addr; a_wdata = a; a_sel = sel; b_data = b;
    b_valid = wr ? 1'b1 : 1'($urandom);
    #1 chk("a_ready", a_ready, 1);
    chk("b_ready", b_ready, wr);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    #1;
    if (legal) begin
      chk("setup_psel", psel, 1 << sel);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, addr);
      chk("setup_pwdata", pwdata, exp_wd);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      for (int i = 0; i <= waits; i++) begin
        pready = i == waits; pslverr = err; prdata = i == waits ? rd : 17'($urandom);
        #1 chk("acc_psel", psel, 1 << sel);
        chk("acc_penable", penable, 1);
        chk("acc_paddr", paddr, addr);
        chk("acc_pwdata", pwdata, exp_wd);
        chk("acc_rsp_valid", rsp_valid, 0);
        @(negedge clk);
      end
      pready = 0; pslverr = 0;
      #1;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_rd);
    chk("rsp_psel", psel, 0);
    chk("rsp_b_ready", b_ready, 0);
    rsp_ready = 0; a_valid = 1; a_write = 0; a_sel = 0;
    for (int i = 0; i < rdly; i++) begin
      #1 chk("bp_a_ready", a_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, exp_rd);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    a_valid = 0;
    #1 chk("done_rsp_valid", rsp_valid, 0);
  endtask
  initial begin
    a_valid = 1; a_write = 1; b_valid = 1;
    repeat (2) @(negedge clk);
    #1 chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0; rst = 1;
    @(negedge clk);
    txn(1, 0, 3, 16'h0005, 16'h0007, 0, 0, 0, 0);
    txn(1, 1, 9, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
    txn(0, 2, 6, 16'h1234, 16'h4321, 3, 0, 17'h0ABCD, 0);
    txn(1, 3, 2, 16'h0011, 16'h0022, 0, 0, 0, 0);
    txn(0, 1, 1, 0, 0, 0, 0, 17'h1F00F, 5);
    txn(0, 0, 4, 0, 0, 1, 1, 17'h12345, 0);
    // write with B missing, then B alone: neither may be consumed
    a_valid = 1; a_write = 1; b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_a_ready", a_ready, 0);
      chk("stall_b_ready", b_ready, 0);
      @(negedge clk);
      chk("stall_psel", psel, 0);
    end
    a_valid = 0; b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("balone_b_ready", b_ready, 0);
      @(negedge clk);
      chk("balone_psel", psel, 0);
    end
    b_valid = 0;
    // reset during ACCESS drops the command silently
    a_valid = 1; a_write = 1; b_valid = 1; a_sel = 1; a_addr = 7; a_wdata = 1; b_data = 2;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    #1 chk("pre_rst_penable", penable, 1);
    rst = 0;
    @(negedge clk);
    #1 chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_paddr", paddr, 0);
    chk("midrst_pwdata", pwdata, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("postrst_rsp_valid", rsp_valid, 0);
      chk("postrst_psel", psel, 0);
    end
`ifdef APB_SUM_BRIDGE_TIMEOUT_EN
    a_valid = 1; a_write = 0; a_sel = 2;
    @(negedge clk);
    a_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 chk("tmo_penable", penable, 1);
      chk("tmo_psel", psel, 3'b100);
      @(negedge clk);
    end
    #1 chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    chk("tmo_psel_drop", psel, 0);
    @(negedge clk);
`else
    // without the timeout an unready slave stalls ACCESS indefinitely
    a_valid = 1; a_write = 0; a_sel = 2;
    @(negedge clk);
    a_valid = 0;
    repeat (21) @(negedge clk);
    #1 chk("hold_penable", penable, 1);
    chk("hold_rsp_valid", rsp_valid, 0);
    pready = 1; prdata = 17'h00042;
    @(negedge clk);
    pready = 0;
    #1 chk("hold_rsp_data", rsp_data, 17'h00042);
    chk("hold_rsp_err", rsp_err, 0);
    @(negedge clk);
`endif
    for (int n = 0; n < 40; n++)
      txn(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 17'($urandom), $urandom_range(0, 2));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
